seed_buffer_reader: RTL
=======================

Name: seed_buffer_reader

Overview:
- Reader end of the jet-seed buffer that the jet selector writes; the selector stores one (eta, phi, et, e) entry per tower slot and zeroes suppressed slots.
- After a frame is written, this block scans slots 0..num_towers-1 in order and drops slots whose et is at or below ET_MIN.
- Surviving seeds are emitted as a compacted valid/ready stream to the downstream jet builder, followed by a frame-done pulse carrying the seed count.

Parameters:
- AW, 10, address width; buffer depth is 2^AW = 1024 entries.
- DW, 10, width of each eta/phi/et/e field.
- ET_MIN, 0, a seed is kept only when et > ET_MIN (unsigned compare).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  buffer write strobe from the selector.
- wr_addr  in  AW  write slot index.
- wr_eta, wr_phi, wr_et, wr_e  in  DW each  tower fields to store.
- wr_reject  out  1  one-cycle pulse when a write is dropped because the block is not IDLE.
- frame_start  in  1  pulse: frame written, begin scan.
- num_towers  in  AW+1  slot count, 0..1024; sampled with frame_start.
- busy  out  1  high in every state except IDLE.
- seed_valid  out  1  output seed valid.
- seed_ready  in  1  downstream accept.
- seed_eta, seed_phi, seed_et, seed_e  out  DW each  seed fields.
- seed_idx  out  AW  buffer slot of the emitted seed.
- frame_done  out  1  one-cycle pulse at end of scan.
- seed_count  out  AW+1  number of seeds emitted this frame; valid while frame_done is high, then held.

Behaviour:
- Reset: all outputs are 0; state goes to IDLE; scan pointer and count are cleared. Buffer contents are not cleared. Reset mid-scan aborts immediately, and no frame_done is issued.
- Buffer: 2^AW x 4*DW single-port-write, synchronous-read RAM with 1-cycle read latency.
  - Writes are accepted only in IDLE.
  - A write in any other state is dropped, and wr_reject pulses in the following cycle.
- FSM states: IDLE, RD, CHK, EMIT, FIN.
  - IDLE: on frame_start, latch num_towers as N and clear ptr and count.
    - N == 0: go to FIN.
    - Otherwise go to RD.
    - frame_start arriving while not in IDLE is ignored.
  - RD: drive read address = ptr, then go to CHK.
  - CHK: read data is available.
    - If et > ET_MIN: register the fields and ptr into the seed outputs, set seed_valid, go to EMIT.
    - Otherwise, if ptr == N-1 go to FIN; else increment ptr and go to RD.
  - EMIT: hold seed_valid and all seed fields stable while seed_ready is low.
    - On seed_valid && seed_ready: clear seed_valid and increment count.
    - Then, if ptr == N-1 go to FIN; else increment ptr and go to RD.
  - FIN: pulse frame_done for one cycle with seed_count = count, then return to IDLE. busy drops in the same cycle that IDLE is entered.
- Timing:
  - frame_start at cycle t gives the first read address at t+1.
  - A kept slot 0 presents seed_valid at t+3.
  - Minimum cost is 3 cycles per kept slot (with ready held high) and 2 cycles per dropped slot.
- Width rules: count saturates naturally at 1024, which fits in AW+1 bits. ptr is AW bits. Comparisons against N use AW+1 bits, so N = 1024 scans slots 0..1023 with no wrap.
- seed_ready while seed_valid is low is ignored. seed_valid never deasserts without a handshake except on reset.

Test Plan:
- Reset with seed_ready held 0 -> all outputs 0, busy 0; wr_en during reset has no effect on outputs.
- Write 4 slots with et = {5, 0, 7, 0} (eta = slot index), frame_start with N = 4, seed_ready = 1 -> seeds emitted with seed_idx 0 then 2 and et 5 then 7; frame_done with seed_count = 2; first seed_valid 3 cycles after frame_start.
- Same frame with seed_ready low for 5 cycles on the first seed -> seed_valid and fields stable across the stall; count stays 0 until the handshake; final seed_count = 2.
- N = 0 -> no seed_valid; frame_done 2 cycles after frame_start with seed_count = 0.
- N = 1024, all et = 1, ET_MIN = 0 -> 1024 seeds, last seed_idx = 1023, seed_count = 1024; wr_en issued mid-scan gives a wr_reject pulse and the buffer is unchanged on a rescan.
- Assert rst during EMIT of the second seed -> next cycle seed_valid = 0, busy = 0, no frame_done; a new frame_start then scans normally.

Source files
------------

// File: rtl/seed_buffer_reader.sv
// seed_buffer_reader: reader side of the jet-seed buffer.
// Holds one (eta, phi, et, e) entry per tower slot. After a frame is written,
// it scans slots 0..N-1 in order, drops entries with et <= ET_MIN, and emits the
// survivors as a compacted valid/ready stream. A frame-done pulse carrying the
// seed count follows the stream.
module seed_buffer_reader #(
    parameter int          AW     = 10,
    parameter int          DW     = 10,
    parameter int unsigned ET_MIN = 0
) (
    input  logic          clk,
    input  logic          rst,
    // write side, driven by the jet selector
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_eta,
    input  logic [DW-1:0] wr_phi,
    input  logic [DW-1:0] wr_et,
    input  logic [DW-1:0] wr_e,
    output logic          wr_reject,
    // frame control
    input  logic          frame_start,
    input  logic [AW:0]   num_towers,
    output logic          busy,
    // seed stream to the jet builder
    output logic          seed_valid,
    input  logic          seed_ready,
    output logic [DW-1:0] seed_eta,
    output logic [DW-1:0] seed_phi,
    output logic [DW-1:0] seed_et,
    output logic [DW-1:0] seed_e,
    output logic [AW-1:0] seed_idx,
    output logic          frame_done,
    output logic [AW:0]   seed_count
);

    localparam logic [DW-1:0] ET_MIN_L = DW'(ET_MIN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW:0]     n_q, n_d;
    logic [AW:0]     count_q, count_d;
    logic            seed_valid_q, seed_valid_d;
    logic [DW-1:0]   seed_eta_q, seed_eta_d;
    logic [DW-1:0]   seed_phi_q, seed_phi_d;
    logic [DW-1:0]   seed_et_q, seed_et_d;
    logic [DW-1:0]   seed_e_q, seed_e_d;
    logic [AW-1:0]   seed_idx_q, seed_idx_d;
    logic            frame_done_q, frame_done_d;
    logic [AW:0]     seed_count_q, seed_count_d;
    logic            busy_q, busy_d;
    logic            wr_reject_q, wr_reject_d;

    // Buffer storage: no reset, contents survive a reset.
    logic [4*DW-1:0] mem_q [2**AW];
    logic [4*DW-1:0] rd_data_q;

    logic [DW-1:0]   rd_eta_s, rd_phi_s, rd_et_s, rd_e_s;
    logic            last_s;

    // Buffer write port: only accepted while idle and out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && (state_q == S_IDLE)) begin
            mem_q[wr_addr] <= {wr_eta, wr_phi, wr_et, wr_e};
        end
    end

    // Synchronous read at the scan pointer; data is valid one cycle later (CHK).
    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[ptr_q];
    end

    assign rd_eta_s = rd_data_q[4*DW-1:3*DW];
    assign rd_phi_s = rd_data_q[3*DW-1:2*DW];
    assign rd_et_s  = rd_data_q[2*DW-1:DW];
    assign rd_e_s   = rd_data_q[DW-1:0];

    // The compare is done in AW+1 bits so N = 2^AW ends at slot 2^AW-1 without wrapping.
    assign last_s = ({1'b0, ptr_q} == (n_q - (AW+1)'(1)));

    // State register and all registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            n_q          <= '0;
            count_q      <= '0;
            seed_valid_q <= 1'b0;
            seed_eta_q   <= '0;
            seed_phi_q   <= '0;
            seed_et_q    <= '0;
            seed_e_q     <= '0;
            seed_idx_q   <= '0;
            frame_done_q <= 1'b0;
            seed_count_q <= '0;
            busy_q       <= 1'b0;
            wr_reject_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            n_q          <= n_d;
            count_q      <= count_d;
            seed_valid_q <= seed_valid_d;
            seed_eta_q   <= seed_eta_d;
            seed_phi_q   <= seed_phi_d;
            seed_et_q    <= seed_et_d;
            seed_e_q     <= seed_e_d;
            seed_idx_q   <= seed_idx_d;
            frame_done_q <= frame_done_d;
            seed_count_q <= seed_count_d;
            busy_q       <= busy_d;
            wr_reject_q  <= wr_reject_d;
        end
    end

    // Scan FSM: next state, scan pointer, count and the next values of the outputs.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        n_d          = n_q;
        count_d      = count_q;
        seed_valid_d = seed_valid_q;
        seed_eta_d   = seed_eta_q;
        seed_phi_d   = seed_phi_q;
        seed_et_d    = seed_et_q;
        seed_e_d     = seed_e_q;
        seed_idx_d   = seed_idx_q;
        frame_done_d = 1'b0;
        seed_count_d = seed_count_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    n_d     = num_towers;
                    ptr_d   = '0;
                    count_d = '0;
                    if (num_towers == {(AW+1){1'b0}}) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                if (rd_et_s > ET_MIN_L) begin
                    seed_eta_d   = rd_eta_s;
                    seed_phi_d   = rd_phi_s;
                    seed_et_d    = rd_et_s;
                    seed_e_d     = rd_e_s;
                    seed_idx_d   = ptr_q;
                    seed_valid_d = 1'b1;
                    state_d      = S_EMIT;
                end else if (last_s) begin
                    state_d = S_FIN;
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = S_RD;
                end
            end
            S_EMIT: begin
                if (seed_valid_q && seed_ready) begin
                    seed_valid_d = 1'b0;
                    count_d      = count_q + (AW+1)'(1);
                    if (last_s) begin
                        state_d = S_FIN;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_FIN: begin
                frame_done_d = 1'b1;
                seed_count_d = count_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy follows the next state, so it drops in the cycle IDLE is entered.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        wr_reject_d = wr_en && (state_q != S_IDLE);
    end

    assign wr_reject  = wr_reject_q;
    assign busy       = busy_q;
    assign seed_valid = seed_valid_q;
    assign seed_eta   = seed_eta_q;
    assign seed_phi   = seed_phi_q;
    assign seed_et    = seed_et_q;
    assign seed_e     = seed_e_q;
    assign seed_idx   = seed_idx_q;
    assign frame_done = frame_done_q;
    assign seed_count = seed_count_q;

endmodule
